// File: rtl/read_path.sv
// -----------------------------------------------------------------------------
// read_path -- AXI4-Lite slave read channel.
//
// Accepts one AR address and issues a single-beat read (REN, ARADDROUT) to the
// register/memory array. When the array answers (RDATAVALID), the data and
// response are captured and returned on the R channel. Only one transaction is
// outstanding at a time. Every output is registered.
//
// Optional macro: AXI_READ_TIMEOUT_EN
//   Defined   : if the array has not answered after TIMEOUT_CYCLES cycles of
//               REN high, a SLVERR beat with zero data is returned instead.
//   Undefined : the read waits for RDATAVALID indefinitely; TIMEOUT_CYCLES is
//               not used.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   ARVALID, ARADDR, ARREADY      AR channel from/to the master
//   REN, ARADDROUT                read request to the array
//   RDATAIN, RRESPIN, RDATAVALID  response from the array
//   RVALID, RDATA, RRESP, RREADY  R channel to/from the master
// -----------------------------------------------------------------------------
module read_path #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int RESP_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ARVALID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARREADY,
    output logic                  REN,
    output logic [ADDR_WIDTH-1:0] ARADDROUT,
    input  logic [DATA_WIDTH-1:0] RDATAIN,
    input  logic [RESP_WIDTH-1:0] RRESPIN,
    input  logic                  RDATAVALID,
    output logic                  RVALID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [RESP_WIDTH-1:0] RRESP,
    input  logic                  RREADY
);

    typedef enum logic [1:0] {IDLE, MEMRD, RESP} state_t;

    state_t                r_state,     w_state_nxt;
    logic                  r_arready,   w_arready_nxt;
    logic                  r_ren,       w_ren_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
    logic                  r_rvalid,    w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_nxt;
    logic [RESP_WIDTH-1:0] r_rresp,     w_rresp_nxt;
    logic                  w_timeout;

`ifdef AXI_READ_TIMEOUT_EN
    localparam int                    CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

    logic [CNT_W-1:0] r_cnt;

    // Counts MEMRD cycles without a response; held at zero elsewhere so it is
    // already clear on entry to MEMRD.
    always_ff @(posedge clk) begin
        if (!reset)
            r_cnt <= '0;
        else if (r_state != MEMRD)
            r_cnt <= '0;
        else if (!RDATAVALID)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // r_cnt lags by one, so CNT==TIMEOUT-1 here is the TIMEOUT-th REN cycle.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_ren     <= 1'b0;
            r_araddr  <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            r_ren     <= w_ren_nxt;
            r_araddr  <= w_araddr_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        w_ren_nxt     = r_ren;
        w_araddr_nxt  = r_araddr;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_state)
            IDLE: begin
                // ARREADY comes up one edge after reset release, so the
                // handshake has to use the registered value.
                w_arready_nxt = 1'b1;
                if (ARVALID && r_arready) begin
                    w_araddr_nxt  = ARADDR;
                    w_arready_nxt = 1'b0;
                    w_ren_nxt     = 1'b1;
                    w_state_nxt   = MEMRD;
                end
            end
            MEMRD: begin
                // A response arriving on the expiry cycle still wins.
                if (RDATAVALID) begin
                    w_rdata_nxt  = RDATAIN;
                    w_rresp_nxt  = RRESPIN;
                    w_rvalid_nxt = 1'b1;
                    w_ren_nxt    = 1'b0;
                    w_state_nxt  = RESP;
                end else if (w_timeout) begin
`ifdef AXI_READ_TIMEOUT_EN
                    w_rresp_nxt  = SLVERR;
`endif
                    w_rdata_nxt  = '0;
                    w_rvalid_nxt = 1'b1;
                    w_ren_nxt    = 1'b0;
                    w_state_nxt  = RESP;
                end
            end
            RESP: begin
                if (r_rvalid && RREADY) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ARREADY   = r_arready;
    assign REN       = r_ren;
    assign ARADDROUT = r_araddr;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RRESP     = r_rresp;

endmodule

// File: tb/tb_read_path.sv
module tb_read_path;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ARVALID;
    logic [AW-1:0] ARADDR;
    logic          ARREADY;
    logic          REN;
    logic [AW-1:0] ARADDROUT;
    logic [DW-1:0] RDATAIN;
    logic [RW-1:0] RRESPIN;
    logic          RDATAVALID;
    logic          RVALID;
    logic [DW-1:0] RDATA;
    logic [RW-1:0] RRESP;
    logic          RREADY;

    int checks = 0;
    int errors = 0;
    logic [DW+RW-1:0] sb_q[$];

    read_path #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .REN(REN), .ARADDROUT(ARADDROUT),
        .RDATAIN(RDATAIN), .RRESPIN(RRESPIN), .RDATAVALID(RDATAVALID),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_arready"}, ARREADY, 0);
        chk({tag, "_ren"}, REN, 0);
        chk({tag, "_araddr"}, ARADDROUT, 0);
        chk({tag, "_rvalid"}, RVALID, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_rresp"}, RRESP, 0);
    endtask

    // Waits (bounded) for an R handshake and compares against the scoreboard.
    task automatic sb_check(input string tag);
        int n = 0;
        logic [DW+RW-1:0] e;
        while (!(RVALID && RREADY) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_rbeat"}, RVALID && RREADY, 1);
        if (RVALID && RREADY) begin
            chk({tag, "_sbdepth"}, sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_rdata"}, RDATA, e[DW+RW-1:RW]);
                chk({tag, "_rresp"}, RRESP, e[RW-1:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; ARVALID = 1'b0; ARADDR = '0; RDATAIN = '0;
        RRESPIN = '0; RDATAVALID = 1'b0; RREADY = 1'b0;

        // Reset held three edges
        for (int i = 0; i < 3; i++) begin
            step();
            chk_rst("rst");
        end
        reset = 1'b1;
        step();
        chk("rst_rel_arready", ARREADY, 1);

        // Minimum-latency read, RREADY already high
        ARVALID = 1'b1; ARADDR = 5'h0A; RREADY = 1'b1;
        step();                                    // edge T
        chk("t1_arready_lo", ARREADY, 0);
        chk("t1_ren", REN, 1);
        chk("t1_araddr", ARADDROUT, 5'h0A);
        ARVALID = 1'b0;
        RDATAVALID = 1'b1; RDATAIN = 32'hDEADBEEF; RRESPIN = 2'b00;
        sb_q.push_back({32'hDEADBEEF, 2'b00});
        step();                                    // edge T+1
        RDATAVALID = 1'b0;
        chk("t1_ren_lo", REN, 0);
        chk("t1_rvalid", RVALID, 1);
        sb_check("t1");
        step();                                    // edge T+2
        chk("t1_rvalid_lo", RVALID, 0);
        chk("t1_arready_back", ARREADY, 1);

        // Back-pressure on R: beat held stable while RREADY low
        ARVALID = 1'b1; ARADDR = 5'h0A; RREADY = 1'b0;
        step();
        ARVALID = 1'b0;
        RDATAVALID = 1'b1; RDATAIN = 32'hDEADBEEF; RRESPIN = 2'b00;
        sb_q.push_back({32'hDEADBEEF, 2'b00});
        step();
        RDATAVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_rvalid_hold", RVALID, 1);
            chk("t2_rdata_hold", RDATA, 32'hDEADBEEF);
            chk("t2_rresp_hold", RRESP, 0);
            chk("t2_arready_lo", ARREADY, 0);
            step();
        end
        RREADY = 1'b1;
        chk("t2_arready_lo_hs", ARREADY, 0);
        sb_check("t2");
        step();
        chk("t2_rvalid_lo", RVALID, 0);
        chk("t2_arready_back", ARREADY, 1);
        chk("t2_rdata_keep", RDATA, 32'hDEADBEEF);

        // Spurious RDATAVALID in IDLE, then a 3-cycle memory delay with SLVERR
        RDATAVALID = 1'b1; RDATAIN = 32'h55AA55AA; RRESPIN = 2'b11;
        step();
        RDATAVALID = 1'b0;
        chk("t3_spur_rvalid", RVALID, 0);
        chk("t3_spur_ren", REN, 0);
        chk("t3_spur_arready", ARREADY, 1);
        ARVALID = 1'b1; ARADDR = 5'h1F; RREADY = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("t3_araddr", ARADDROUT, 5'h1F);
        for (int i = 0; i < 3; i++) begin
            chk("t3_ren_hi", REN, 1);
            chk("t3_rvalid_lo", RVALID, 0);
            if (i < 2) step();
        end
        RDATAVALID = 1'b1; RDATAIN = 32'h0; RRESPIN = 2'b10;
        sb_q.push_back({32'h0, 2'b10});
        step();
        RDATAVALID = 1'b0;
        chk("t3_ren_lo", REN, 0);
        sb_check("t3");
        step();
        chk("t3_arready_back", ARREADY, 1);

        // Reset while RESP holds a beat: beat dropped
        ARVALID = 1'b1; ARADDR = 5'h11; RREADY = 1'b0;
        step();
        ARVALID = 1'b0;
        RDATAVALID = 1'b1; RDATAIN = 32'hCAFEF00D; RRESPIN = 2'b01;
        step();
        RDATAVALID = 1'b0;
        chk("t4_rvalid_pre", RVALID, 1);
        reset = 1'b0;
        step();
        chk_rst("t4_rst");
        reset = 1'b1;
        RREADY = 1'b1;
        step();
        chk("t4_rvalid_none", RVALID, 0);
        chk("t4_arready", ARREADY, 1);
        ARVALID = 1'b1; ARADDR = 5'h03;
        step();
        ARVALID = 1'b0;
        chk("t4_araddr", ARADDROUT, 5'h03);
        RDATAVALID = 1'b1; RDATAIN = 32'h12345678; RRESPIN = 2'b01;
        sb_q.push_back({32'h12345678, 2'b01});
        step();
        RDATAVALID = 1'b0;
        sb_check("t4");
        step();
        chk("t4_arready_back", ARREADY, 1);

`ifdef AXI_READ_TIMEOUT_EN
        // Memory never answers: SLVERR after exactly 4 REN cycles
        ARVALID = 1'b1; ARADDR = 5'h07; RREADY = 1'b0;
        step();
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_ren_hi", REN, 1);
            chk("t5_rvalid_lo", RVALID, 0);
            step();
        end
        chk("t5_ren_lo", REN, 0);
        chk("t5_rvalid", RVALID, 1);
        sb_q.push_back({32'h0, 2'b10});
        RREADY = 1'b1;
        sb_check("t5");
        step();
        chk("t5_arready_back", ARREADY, 1);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/read_path.md
Name: read_path

Overview:
- AXI4-Lite slave read path: the read-side counterpart of the slave write path.
- Accepts one read address on the AR channel and issues a single-beat read request to the register/memory array.
- Captures the memory's data and response, then returns them to the master on the R channel.
- One transaction outstanding at a time; sits beside the write path in the slave top.

Parameters:
- DATA_WIDTH, 32, width of read data bus.
- ADDR_WIDTH, 5, width of read address.
- RESP_WIDTH, 2, width of response code.
- TIMEOUT_CYCLES, 16, memory-response timeout in cycles (used only with the optional feature; must be ≥1).

Ports:
- clk  in  1  global clock.
- reset  in  1  synchronous, active-low reset.
- ARVALID  in  1  master read-address valid.
- ARADDR  in  ADDR_WIDTH  master read address.
- ARREADY  out  1  slave ready to accept an address.
- REN  out  1  memory read enable.
- ARADDROUT  out  ADDR_WIDTH  latched address to memory.
- RDATAIN  in  DATA_WIDTH  read data from memory.
- RRESPIN  in  RESP_WIDTH  response code from memory.
- RDATAVALID  in  1  memory has RDATAIN/RRESPIN valid.
- RVALID  out  1  read data valid to master.
- RDATA  out  DATA_WIDTH  read data to master.
- RRESP  out  RESP_WIDTH  read response to master.
- RREADY  in  1  master ready for read data.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low; all outputs are registered.
- Reset values: ARREADY=0, REN=0, ARADDROUT=0, RVALID=0, RDATA=0, RRESP=0, state=IDLE.
- ARREADY rises to 1 on the first clock edge after reset deasserts.
- FSM states: IDLE, MEMRD, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&&ARREADY at edge T: ARADDROUT<=ARADDR, ARREADY<=0, REN<=1, go MEMRD.
  - ARVALID low: stay in IDLE, outputs held.
- MEMRD:
  - REN held 1, ARADDROUT stable.
  - On RDATAVALID: RDATA<=RDATAIN, RRESP<=RRESPIN, RVALID<=1, REN<=0, go RESP.
  - Without RDATAVALID: wait.
- RESP:
  - RVALID, RDATA and RRESP held stable until RREADY.
  - On RVALID&&RREADY: RVALID<=0, ARREADY<=1, go IDLE.
  - RDATA/RRESP retain their last value after the handshake.
- Minimum latency:
  - AR handshake at edge T; REN high in cycle T+1.
  - If RDATAVALID is seen at edge T+1, RVALID is high in cycle T+2.
  - If RREADY is already high, ARREADY is high again in cycle T+3.
- Back-to-back reads: the next address is accepted no earlier than the cycle after the R handshake; no AR/R overlap.
- RDATAVALID outside MEMRD is ignored.
- RREADY outside RESP is ignored.
- ARVALID outside IDLE is not accepted; the master holds it per AXI.
- Reset asserted in any state: the in-flight transaction is dropped; all outputs return to reset values on that edge; no R beat is produced.
- No address decode: every address is forwarded; the error code comes from RRESPIN.

Optional Feature:
- Macro: AXI_READ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to MEMRD and increments each MEMRD cycle without RDATAVALID.
  - If RDATAVALID has not arrived after TIMEOUT_CYCLES REN-high cycles: REN<=0, RDATA<=0, RRESP<=2'b10 (SLVERR), RVALID<=1, go RESP.
  - RDATAVALID in the same cycle as expiry wins: normal data is returned.
- Not defined: no counter is instantiated; MEMRD waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset low 3 cycles, then high → all outputs 0 during reset; ARREADY=1 one cycle after release.
- ARADDR=5'h0A with ARVALID; memory returns 32'hDEADBEEF/2'b00 one cycle after REN; RREADY held 1 → REN 1 cycle; RVALID in cycle T+2 with RDATA=32'hDEADBEEF, RRESP=0; ARREADY back at T+3.
- Same read, but RREADY held low 4 cycles after RVALID → RVALID/RDATA/RRESP stable all 4 cycles; ARREADY stays 0 until the cycle after RREADY.
- Memory returns RRESPIN=2'b10, RDATAIN=32'h0 after a 3-cycle delay; spurious RDATAVALID pulse while IDLE → REN high 3 cycles, RRESP=2'b10; spurious pulse produces no RVALID.
- Reset pulsed while in RESP with RVALID=1 → RVALID=0 on the next edge; ARREADY=1 the cycle after release; a new read completes normally.
- With AXI_READ_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never responds → REN high exactly 4 cycles, then RVALID=1, RDATA=0, RRESP=2'b10.
